// File: rtl/top_pcie_c2h_rdm.sv
// C2H data mover: reads board DRAM beat by beat and emits header+payload write packets.
// Optional C2H_STATS_EN adds packet/byte counters (stat_pkts, stat_bytes).
module top_pcie_c2h_rdm #(
    parameter int DATA_W            = 64,
    parameter int MAX_PAYLOAD_BYTES = 512,
    parameter int LINKUP_DLY        = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              phy_lnk_up,
    output logic              user_lnk_up,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [31:0]       desc_src_addr,
    input  logic [63:0]       desc_dst_addr,
    input  logic [15:0]       desc_len,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [31:0]       mem_rd_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              c2h_tvalid,
    input  logic              c2h_tready,
    output logic [DATA_W-1:0] c2h_tdata,
    output logic [7:0]        c2h_tkeep,
    output logic              c2h_tlast,
    output logic              done,
    output logic              busy
`ifdef C2H_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_bytes
`endif
);

    localparam int              CNT_W   = $clog2(LINKUP_DLY + 1);
    localparam logic [CNT_W-1:0] LNK_MAX = CNT_W'(LINKUP_DLY);
    localparam logic [15:0]     MAX_PL  = 16'(MAX_PAYLOAD_BYTES);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR0   = 3'd1;
    localparam logic [2:0] HDR1   = 3'd2;
    localparam logic [2:0] RDREQ  = 3'd3;
    localparam logic [2:0] RDWAIT = 3'd4;
    localparam logic [2:0] DATA   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [CNT_W-1:0] lnk_cnt;
    logic [2:0]       state;
    logic [63:0]      dst_ptr;
    logic [31:0]      src_ptr;
    logic [15:0]      rem_len;
    logic [15:0]      chunk_len;
    logic [15:0]      beat_left;
    logic [15:0]      desc_chunk;
    logic [15:0]      next_chunk;
    logic             c2h_hs;
    logic             last_beat;

    function automatic logic [15:0] chunk_of(input logic [15:0] r);
        return (r > MAX_PL) ? MAX_PL : r;
    endfunction

    // Low (n mod 8) byte lanes, or all lanes when the beat is full.
    function automatic logic [7:0] keep_of(input logic [15:0] n);
        if (n[2:0] == 3'd0) return 8'hFF;
        return 8'hFF >> (4'd8 - {1'b0, n[2:0]});
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)               lnk_cnt <= '0;
        else if (!phy_lnk_up)         lnk_cnt <= '0;
        else if (lnk_cnt != LNK_MAX)  lnk_cnt <= lnk_cnt + 1'b1;
    end

    assign user_lnk_up  = (lnk_cnt == LNK_MAX);
    assign desc_ready   = (state == IDLE) && user_lnk_up;
    assign mem_rd_valid = (state == RDREQ);
    assign mem_rd_addr  = src_ptr;
    assign done         = (state == DONE);
    assign busy         = (state != IDLE);
    assign c2h_hs       = c2h_tvalid && c2h_tready;
    assign desc_chunk   = chunk_of(desc_len);
    assign next_chunk   = chunk_of(rem_len);
    assign last_beat    = (beat_left <= 16'd8);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            dst_ptr    <= '0;
            src_ptr    <= '0;
            rem_len    <= '0;
            chunk_len  <= '0;
            beat_left  <= '0;
            c2h_tvalid <= 1'b0;
            c2h_tdata  <= '0;
            c2h_tkeep  <= '0;
            c2h_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (desc_valid && desc_ready) begin
                    src_ptr <= desc_src_addr;
                    dst_ptr <= desc_dst_addr;
                    if (desc_len == 16'd0) begin
                        state <= DONE;
                    end else begin
                        chunk_len  <= desc_chunk;
                        beat_left  <= desc_chunk;
                        rem_len    <= desc_len - desc_chunk;
                        c2h_tvalid <= 1'b1;
                        c2h_tdata  <= desc_dst_addr;
                        c2h_tkeep  <= 8'hFF;
                        c2h_tlast  <= 1'b0;
                        state      <= HDR0;
                    end
                end
                HDR0: if (c2h_hs) begin
                    c2h_tdata <= {48'h0, chunk_len};
                    state     <= HDR1;
                end
                HDR1: if (c2h_hs) begin
                    c2h_tvalid <= 1'b0;
                    state      <= RDREQ;
                end
                RDREQ: if (mem_rd_ready) begin
                    src_ptr <= src_ptr + 32'd8;
                    state   <= RDWAIT;
                end
                RDWAIT: if (mem_rsp_valid) begin
                    c2h_tvalid <= 1'b1;
                    c2h_tdata  <= mem_rsp_data;
                    c2h_tlast  <= last_beat;
                    c2h_tkeep  <= last_beat ? keep_of(beat_left) : 8'hFF;
                    state      <= DATA;
                end
                DATA: if (c2h_hs) begin
                    c2h_tvalid <= 1'b0;
                    c2h_tlast  <= 1'b0;
                    if (!c2h_tlast) begin
                        beat_left <= beat_left - 16'd8;
                        state     <= RDREQ;
                    end else if (rem_len != 16'd0) begin
                        // Next chunk's header goes out straight from here.
                        dst_ptr    <= dst_ptr + {48'h0, chunk_len};
                        chunk_len  <= next_chunk;
                        beat_left  <= next_chunk;
                        rem_len    <= rem_len - next_chunk;
                        c2h_tvalid <= 1'b1;
                        c2h_tdata  <= dst_ptr + {48'h0, chunk_len};
                        c2h_tkeep  <= 8'hFF;
                        state      <= HDR0;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef C2H_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else if (c2h_hs && c2h_tlast) begin
            stat_pkts  <= stat_pkts + 32'd1;
            stat_bytes <= stat_bytes + {16'h0, chunk_len};
        end
    end
`endif

endmodule

// File: tb/tb_top_pcie_c2h_rdm.sv
// Directed bench for top_pcie_c2h_rdm: DRAM responder, stream sink and per-step assertions.
module tb_top_pcie_c2h_rdm;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        phy_lnk_up;
    logic        user_lnk_up;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_src_addr;
    logic [63:0] desc_dst_addr;
    logic [15:0] desc_len;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        c2h_tvalid;
    logic        c2h_tready;
    logic [63:0] c2h_tdata;
    logic [7:0]  c2h_tkeep;
    logic        c2h_tlast;
    logic        done;
    logic        busy;
`ifdef C2H_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_bytes;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int viol  = 0;
    int tvalid_cycles = 0;
    int rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random
    bit mem_bp = 1'b0;
    beat_t got_q[$];
    beat_t exp_q[$];

    top_pcie_c2h_rdm dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .phy_lnk_up(phy_lnk_up), .user_lnk_up(user_lnk_up),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr), .desc_len(desc_len),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready), .c2h_tdata(c2h_tdata),
        .c2h_tkeep(c2h_tkeep), .c2h_tlast(c2h_tlast),
        .done(done), .busy(busy)
`ifdef C2H_STATS_EN
        , .stat_pkts(stat_pkts), .stat_bytes(stat_bytes)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    // DRAM model: handshake captured at the edge, response one cycle later.
    logic        rd_hs = 1'b0;
    logic [31:0] rd_hs_addr = '0;
    always @(posedge sys_clk) begin
        rd_hs      <= mem_rd_valid & mem_rd_ready;
        rd_hs_addr <= mem_rd_addr;
    end

    initial begin
        int dly;
        dly = 0;
        mem_rd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        c2h_tready = 1'b1;
        forever begin
            @(negedge sys_clk);
            mem_rsp_valid = rd_hs;
            mem_rsp_data  = rd_hs ? mem_word(rd_hs_addr) : 64'h0;
            if (rd_hs) begin
                mem_rd_ready = 1'b0;
                dly = mem_bp ? int'($urandom_range(3, 0)) : 0;
            end
            if (mem_rd_valid && !mem_rd_ready) begin
                if (dly == 0) mem_rd_ready = 1'b1;
                else dly--;
            end
            c2h_tready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
        end
    end

    // Stream sink plus hold-while-stalled monitor.
    beat_t pb;
    logic  pv = 1'b0, pr = 1'b0;
    always @(posedge sys_clk) begin
        if (done) done_cnt++;
        if (!sys_rst_n) begin
            pv <= 1'b0;
        end else begin
            if (c2h_tvalid) tvalid_cycles++;
            if (c2h_tvalid && c2h_tready) got_q.push_back('{c2h_tdata, c2h_tkeep, c2h_tlast});
            if (pv && !pr && !(c2h_tvalid && pb === beat_t'({c2h_tdata, c2h_tkeep, c2h_tlast}))) viol++;
            pv <= c2h_tvalid;
            pr <= c2h_tready;
            pb <= '{c2h_tdata, c2h_tkeep, c2h_tlast};
        end
    end

    task automatic build_exp(input logic [31:0] s, input logic [63:0] d, input logic [15:0] len);
        int rem, c, nb, r;
        exp_q.delete();
        rem = int'(len);
        while (rem > 0) begin
            c = (rem > 512) ? 512 : rem;
            exp_q.push_back('{d, 8'hFF, 1'b0});
            exp_q.push_back('{{48'h0, 16'(c)}, 8'hFF, 1'b0});
            nb = (c + 7) / 8;
            r  = c % 8;
            for (int b = 0; b < nb; b++) begin
                logic lst;
                lst = (b == nb - 1);
                exp_q.push_back('{mem_word(s), (lst && r != 0) ? 8'(8'hFF >> (8 - r)) : 8'hFF, lst});
                s += 32'd8;
            end
            d   += 64'(c);
            rem -= c;
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_beats"}, 0, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_tdata"}, i, 128'(got_q[i].d), 128'(exp_q[i].d));
            chk({tag, "_tkeep"}, i, 128'(got_q[i].k), 128'(exp_q[i].k));
            chk({tag, "_tlast"}, i, 128'(got_q[i].l), 128'(exp_q[i].l));
        end
    endtask

    task automatic send_desc(input logic [31:0] s, input logic [63:0] d, input logic [15:0] l);
        int n;
        n = 0;
        @(negedge sys_clk);
        desc_valid = 1'b1;
        desc_src_addr = s;
        desc_dst_addr = d;
        desc_len = l;
        while (!desc_ready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("desc_accept", 0, 128'(desc_ready), 128'(1));
        @(posedge sys_clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("done_seen", 0, 128'(done_cnt - start), 128'(1));
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 0,
            128'({user_lnk_up, desc_ready, mem_rd_valid, c2h_tvalid, c2h_tlast, done, busy}), 128'(0));
        chk({tag, "_tdata"}, 0, 128'(c2h_tdata), 128'(0));
        chk({tag, "_tkeep"}, 0, 128'(c2h_tkeep), 128'(0));
        chk({tag, "_rdaddr"}, 0, 128'(mem_rd_addr), 128'(0));
    endtask

    task automatic qualify_link();
        @(negedge sys_clk);
        phy_lnk_up = 1'b1;
        repeat (17) @(posedge sys_clk);
        #1;
        chk("lnk_requal", 0, 128'(user_lnk_up), 128'(1));
    endtask

    initial begin
`ifdef C2H_STATS_EN
        logic [31:0] p0, b0;
`endif
        sys_rst_n = 1'b0;
        phy_lnk_up = 1'b0;
        desc_valid = 1'b0;
        desc_src_addr = '0;
        desc_dst_addr = '0;
        desc_len = '0;
        #23;
        chk_all_zero("reset");

        // Link qualification: 15 cycles not enough, 16th raises it.
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        phy_lnk_up = 1'b1;
        repeat (15) @(posedge sys_clk);
        #1;
        chk("lnk_15", 0, 128'(user_lnk_up), 128'(0));
        @(posedge sys_clk);
        #1;
        chk("lnk_16", 0, 128'(user_lnk_up), 128'(1));
        chk("ready_up", 0, 128'(desc_ready), 128'(1));
        @(negedge sys_clk);
        phy_lnk_up = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("lnk_drop", 0, 128'(user_lnk_up), 128'(0));

        // Gating: descriptor offered while link is down is never taken.
        desc_valid = 1'b1;
        desc_len = 16'd8;
        repeat (5) @(negedge sys_clk);
        chk("gate_ready", 0, 128'(desc_ready), 128'(0));
        chk("gate_busy", 0, 128'(busy), 128'(0));
        desc_valid = 1'b0;
        qualify_link();

        // Single small transfer.
        got_q.delete();
        send_desc(32'h100, 64'h1_0000_0000, 16'd24);
        wait_done(500);
        exp_q.delete();
        exp_q.push_back('{64'h1_0000_0000, 8'hFF, 1'b0});
        exp_q.push_back('{64'h18, 8'hFF, 1'b0});
        exp_q.push_back('{{32'hFFFF_FEFF, 32'h0000_0100}, 8'hFF, 1'b0});
        exp_q.push_back('{{32'hFFFF_FEF7, 32'h0000_0108}, 8'hFF, 1'b0});
        exp_q.push_back('{{32'hFFFF_FEEF, 32'h0000_0110}, 8'hFF, 1'b1});
        cmp_stream("small");
        chk("small_busy", 0, 128'(busy), 128'(0));

        // Chunking with partial final beat.
`ifdef C2H_STATS_EN
        p0 = stat_pkts;
        b0 = stat_bytes;
`endif
        got_q.delete();
        send_desc(32'h2000, 64'h8000_0000_0000, 16'd1028);
        wait_done(5000);
        chk("chunk_beats", 0, 128'(got_q.size()), 128'(135));
        if (got_q.size() == 135) begin
            chk("chunk_hdr0", 0, 128'(got_q[0].d), 128'(64'h8000_0000_0000));
            chk("chunk_len0", 0, 128'(got_q[1].d), 128'(64'h200));
            chk("chunk_hdr1", 0, 128'(got_q[66].d), 128'(64'h8000_0000_0200));
            chk("chunk_hdr2", 0, 128'(got_q[132].d), 128'(64'h8000_0000_0400));
            chk("chunk_len2", 0, 128'(got_q[133].d), 128'(64'h4));
            chk("chunk_keep", 0, 128'(got_q[134].k), 128'(8'h0F));
            chk("chunk_last", 0, 128'(got_q[134].l), 128'(1));
        end
        build_exp(32'h2000, 64'h8000_0000_0000, 16'd1028);
        cmp_stream("chunk");
`ifdef C2H_STATS_EN
        chk("stat_pkts", 0, 128'(stat_pkts - p0), 128'(3));
        chk("stat_bytes", 0, 128'(stat_bytes - b0), 128'(1028));
`endif

        // Backpressure on both sides.
        got_q.delete();
        viol = 0;
        rdy_mode = 2;
        mem_bp = 1'b1;
        send_desc(32'h3000, 64'h1234_5678, 16'd100);
        wait_done(3000);
        build_exp(32'h3000, 64'h1234_5678, 16'd100);
        cmp_stream("bp");
        chk("bp_stable", 0, 128'(viol), 128'(0));
        rdy_mode = 1;
        mem_bp = 1'b0;

        // Zero length: straight to DONE, no stream activity.
        got_q.delete();
        tvalid_cycles = 0;
        send_desc(32'h500, 64'h9000, 16'd0);
        chk("zero_done", 0, 128'(done), 128'(1));
        @(posedge sys_clk);
        #1;
        chk("zero_done_end", 0, 128'({done, busy}), 128'(0));
        repeat (4) @(negedge sys_clk);
        chk("zero_tvalid", 0, 128'(tvalid_cycles), 128'(0));

        // Reset while a data beat is stalled.
        got_q.delete();
        send_desc(32'h6000, 64'h7000, 16'd64);
        for (int n = 0; n < 100 && got_q.size() < 2; n++) @(negedge sys_clk);
        rdy_mode = 0;
        @(negedge sys_clk);
        for (int n = 0; n < 100 && !c2h_tvalid; n++) @(negedge sys_clk);
        chk("rst_in_data", 0, 128'(c2h_tvalid), 128'(1));
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rdy_mode = 1;
        qualify_link();
        got_q.delete();
        send_desc(32'h4000, 64'h55, 16'd8);
        wait_done(500);
        build_exp(32'h4000, 64'h55, 16'd8);
        cmp_stream("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
